dadda_mult_seq_ctrl: RTL and testbench
======================================

Name: dadda_mult_seq_ctrl

Overview:
- Sequences a batch of operand pairs through the pipelined Dadda multiplier.
- Reads operands from a 1-cycle-latency operand ROM, drives the multiplier inputs, and writes each product to a result RAM.
- Checks each product against an internal golden product and counts mismatches.
- Sits inside design_1_wrapper between the operand/result memories and the multiplier; it is the block that makes the wrapper self-running.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH.
- NUM_VECTORS, 16, number of operand pairs per run; must be at least 1.
- ADDR_W, 4, memory address width; 2**ADDR_W >= NUM_VECTORS.
- MULT_LATENCY, 2, cycles from mult_a/mult_b registered to mult_p valid; 0 means combinational.
- ERR_W, 8, width of the error counter.

Ports:
- sys_clock  in  1  single system clock; all logic on its rising edge.
- reset_rtl  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; starts a run when sampled high in IDLE.
- busy  out  1  high from the cycle after start is accepted until the done pulse, inclusive.
- done  out  1  one-cycle pulse when the run completes.
- op_rd_en  out  1  operand ROM read enable.
- op_addr  out  ADDR_W  operand ROM address.
- op_a, op_b  in  WIDTH each  ROM data, valid 1 cycle after op_rd_en.
- mult_a, mult_b  out  WIDTH each  registered multiplier operands.
- mult_p  in  2*WIDTH  multiplier product.
- res_we  out  1  result RAM write enable.
- res_addr  out  ADDR_W  result RAM address.
- res_data  out  2*WIDTH  result RAM write data, equal to mult_p.
- err_count  out  ERR_W  number of mismatches in the current or last run; saturates at all-ones.

Behaviour:
- Reset (synchronous, reset_rtl=1 at a clock edge):
  - Returns to IDLE.
  - All outputs 0, including err_count; the valid pipeline is flushed.
  - A reset mid-run abandons the run: no further res_we and no done pulse.
- States:
  - IDLE: waits for start=1.
  - ISSUE: issues NUM_VECTORS reads.
  - DRAIN: waits until the outstanding count is 0.
  - DONE: single cycle, then IDLE.
- Timing, with cycle 0 = the edge that samples start=1 in IDLE:
  - The cycle-0 edge clears err_count and enters ISSUE.
  - ISSUE lasts cycles 1..NUM_VECTORS. In cycle k+1, op_rd_en=1 and op_addr=k, for k=0..NUM_VECTORS-1, with no gaps.
  - op_a/op_b for vector k arrive in cycle k+2 and are registered onto mult_a/mult_b, visible in cycle k+3. mult_a/mult_b hold their last value otherwise.
  - A valid shift register of depth 2+MULT_LATENCY tags each issue.
  - In cycle k+3+MULT_LATENCY: res_we=1, res_addr=k, res_data=mult_p.
  - In the same cycle, mult_p is compared with the golden product (the registered mult_a times mult_b, delayed MULT_LATENCY cycles). On mismatch, err_count increments, saturating.
  - After the last issue, the FSM moves to DRAIN. done=1 in the cycle after the final res_we, i.e. cycle NUM_VECTORS+3+MULT_LATENCY. The FSM then returns to IDLE.
- busy: high in cycles 1 through the done cycle.
- Handshake rules:
  - start while busy is ignored.
  - start held high continuously produces back-to-back runs. Each new run is accepted in the IDLE cycle after done.
- err_count holds its value after done until the next accepted start.
- Width rules:
  - The golden product is computed at full 2*WIDTH unsigned width; no truncation.
  - Addresses are zero-extended to ADDR_W.
- NUM_VECTORS=1: a single read, and done in cycle 4+MULT_LATENCY.

Test Plan:
1. Correct multiplier model, ROM[k]=(k, k+1), WIDTH=8, N=16, L=2, start pulse at cycle 0 -> res_we in cycles 5..20 with res_addr=k and res_data=k*(k+1) (e.g. addr 15 gets 240); done in cycle 21 only; err_count=0; busy high in cycles 1..21.
2. Corner operands ROM: (255,255), (0,200), (255,1), (128,2) -> results 65025, 0, 255, 256; err_count=0.
3. Faulty multiplier model that flips bit 0 of the product for vectors 5 and 9 -> err_count=2 after done; res_data shows the faulty values; the next run with a correct model clears err_count to 0.
4. start pulsed again in cycles 3 and 10 of a run -> ignored; exactly 16 res_we and one done pulse.
5. reset_rtl asserted in cycle 8 for one cycle -> from cycle 9: all outputs 0, no res_we, no done; a fresh start then completes a normal run.
6. start held high for 60 cycles -> back-to-back runs with done pulses in cycles 21 and 43 (second run accepted in cycle 22); busy low only in cycle 22.

Source files
------------

// File: rtl/dadda_mult_seq_ctrl.sv
// Batch sequencer for the pipelined Dadda multiplier.
// Streams ROM operands in, writes products out, counts mismatches.
module dadda_mult_seq_ctrl #(
  parameter int WIDTH        = 8,
  parameter int NUM_VECTORS  = 16,
  parameter int ADDR_W       = 4,
  parameter int MULT_LATENCY = 2,
  parameter int ERR_W        = 8
) (
  input  logic                 sys_clock,
  input  logic                 reset_rtl,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 op_rd_en,
  output logic [ADDR_W-1:0]    op_addr,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_p,
  output logic                 res_we,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [2*WIDTH-1:0]   res_data,
  output logic [ERR_W-1:0]     err_count
);

  localparam int D  = 2 + MULT_LATENCY;
  localparam int PW = 2 * WIDTH;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [D-1:0]      vld_q, vld_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              issue;
  logic              accept;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     gold;

  assign prod = {{WIDTH{1'b0}}, a_q} *
                {{WIDTH{1'b0}}, b_q};

  generate
    if (MULT_LATENCY == 0) begin : g_comb
      assign gold = prod;
    end else begin : g_pipe
      logic [MULT_LATENCY-1:0][PW-1:0] gold_q;
      logic [MULT_LATENCY-1:0][PW-1:0] gold_d;

      // Delay the golden product to line up with mult_p.
      always_comb begin
        gold_d    = gold_q;
        gold_d[0] = prod;
        for (int i = 1; i < MULT_LATENCY; i++) begin
          gold_d[i] = gold_q[i-1];
        end
      end

      // Golden delay line registers.
      always_ff @(posedge sys_clock) begin
        if (reset_rtl) gold_q <= '0;
        else           gold_q <= gold_d;
      end

      assign gold = gold_q[MULT_LATENCY-1];
    end
  endgenerate

  assign res_we = vld_q[D-1];

  // Next-state logic; DRAIN exits once no tag remains in flight.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (rd_cnt_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: counters, valid tags, operands, errors.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    vld_d    = {vld_q[D-2:0], issue};
    if (accept) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      err_d    = '0;
    end
    if (issue) rd_cnt_d = rd_cnt_q + ADDR_W'(1);
    if (vld_q[0]) begin
      a_d = op_a;
      b_d = op_b;
    end
    if (res_we) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      if (mult_p != gold && err_q != '1) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      vld_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      vld_q    <= vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign op_rd_en  = issue;
  assign op_addr   = rd_cnt_q;
  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign res_addr  = wr_cnt_q;
  assign res_data  = res_we ? mult_p : '0;
  assign err_count = err_q;

endmodule

// File: tb/tb_dadda_mult_seq_ctrl.sv
// Bench for dadda_mult_seq_ctrl: ROM and multiplier models,
// a run-relative reference model and a per-cycle comparator.
module tb_dadda_mult_seq_ctrl;

  localparam int N = 16;
  localparam int L = 2;

  logic        clk;
  logic        reset_rtl;
  logic        start;
  logic        busy;
  logic        done;
  logic        op_rd_en;
  logic [3:0]  op_addr;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_p;
  logic        res_we;
  logic [3:0]  res_addr;
  logic [15:0] res_data;
  logic [7:0]  err_count;

  dadda_mult_seq_ctrl #(
    .WIDTH(8), .NUM_VECTORS(N), .ADDR_W(4),
    .MULT_LATENCY(L), .ERR_W(8)
  ) dut (
    .sys_clock(clk),
    .reset_rtl(reset_rtl),
    .start(start),
    .busy(busy),
    .done(done),
    .op_rd_en(op_rd_en),
    .op_addr(op_addr),
    .op_a(op_a),
    .op_b(op_b),
    .mult_a(mult_a),
    .mult_b(mult_b),
    .mult_p(mult_p),
    .res_we(res_we),
    .res_addr(res_addr),
    .res_data(res_data),
    .err_count(err_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  rom_a [N];
  logic [7:0]  rom_b [N];
  logic        fault_en;
  logic [15:0] p1, p2;

  always @(posedge clk) begin
    if (op_rd_en) begin
      op_a <= rom_a[op_addr];
      op_b <= rom_b[op_addr];
    end
  end

  function automatic logic mul_flip(
    input logic [7:0] a, input logic [7:0] b);
    mul_flip = fault_en &&
      ((a == rom_a[5] && b == rom_b[5]) ||
       (a == rom_a[9] && b == rom_b[9]));
  endfunction

  always @(posedge clk) begin
    p1 <= (16'(mult_a) * 16'(mult_b)) ^
          16'(mul_flip(mult_a, mult_b));
    p2 <= p1;
  end
  assign mult_p = p2;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic is_fault(input int k);
    is_fault = fault_en && (k == 5 || k == 9);
  endfunction

  function automatic logic [15:0] exp_p(input int k);
    exp_p = (16'(rom_a[k]) * 16'(rom_b[k])) ^
            16'(is_fault(k));
  endfunction

  int         cyc = 0;
  logic       m_active = 0;
  int         m_rel = 0;
  logic [7:0] m_err = 0;
  logic [7:0] m_ma = 0;
  logic [7:0] m_mb = 0;
  logic       m_post_rst = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset_rtl) begin
      m_active   = 0;
      m_rel      = 0;
      m_err      = 0;
      m_ma       = 0;
      m_mb       = 0;
      m_post_rst = 1;
    end else if (m_active) begin
      if (m_rel >= 2 && m_rel <= N + 1) begin
        m_ma = rom_a[m_rel-2];
        m_mb = rom_b[m_rel-2];
      end
      if (m_rel >= 3 + L && m_rel <= N + 2 + L &&
          is_fault(m_rel - 3 - L) && m_err != 8'hff)
        m_err = m_err + 8'd1;
      if (m_rel == N + 3 + L) begin
        m_active = 0;
        m_rel    = 0;
      end else begin
        m_rel = m_rel + 1;
      end
    end else if (start) begin
      m_active   = 1;
      m_rel      = 1;
      m_err      = 0;
      m_post_rst = 0;
    end
  end

  logic [15:0] cap [N];
  int          n_we;
  int          n_done;
  int          done_rel;
  int          done_q [$];

  always @(negedge clk) begin
    logic e_rd, e_we, e_done;
    int   k;
    if (cyc > 0) begin
      e_rd   = m_active && m_rel >= 1 && m_rel <= N;
      e_we   = m_active && m_rel >= 3 + L &&
               m_rel <= N + 2 + L;
      e_done = m_active && m_rel == N + 3 + L;
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("op_rd_en", 32'(op_rd_en), 32'(e_rd));
      chk("res_we", 32'(res_we), 32'(e_we));
      chk("mult_a", 32'(mult_a), 32'(m_ma));
      chk("mult_b", 32'(mult_b), 32'(m_mb));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (e_rd)
        chk("op_addr", 32'(op_addr), 32'(m_rel - 1));
      if (e_we) begin
        k = m_rel - 3 - L;
        chk("res_addr", 32'(res_addr), 32'(k));
        chk("res_data", 32'(res_data), 32'(exp_p(k)));
        cap[k] = res_data;
      end
      if (m_post_rst) begin
        chk("rst_op_addr", 32'(op_addr), 0);
        chk("rst_res_addr", 32'(res_addr), 0);
        chk("rst_res_data", 32'(res_data), 0);
      end
      if (res_we) n_we++;
      if (done) begin
        n_done++;
        done_rel = m_rel;
        done_q.push_back(cyc);
      end
    end
  end

  task automatic wait_done();
    logic got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
    end
    chk("done_timeout", 32'(got), 1);
    @(negedge clk);
    #2;
  endtask

  task automatic wait_rel(input int r);
    logic got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #2;
      if (m_active && m_rel == r) got = 1;
    end
    chk("rel_timeout", 32'(got), 1);
  endtask

  task automatic run();
    n_we   = 0;
    n_done = 0;
    start  = 1;
    @(negedge clk);
    #2;
    start = 0;
    wait_done();
  endtask

  initial begin
    int t0, lows, low_at, d0, d1;
    reset_rtl = 1;
    start     = 0;
    fault_en  = 0;
    for (int k = 0; k < N; k++) begin
      rom_a[k] = 8'(k);
      rom_b[k] = 8'(k + 1);
    end
    repeat (3) @(negedge clk);
    #2;
    reset_rtl = 0;
    @(negedge clk);
    #2;

    run();
    chk("t1_addr15", 32'(cap[15]), 240);
    chk("t1_addr0", 32'(cap[0]), 0);
    chk("t1_addr7", 32'(cap[7]), 56);
    chk("t1_done_rel", done_rel, 21);
    chk("t1_n_we", n_we, 16);
    chk("t1_err", 32'(err_count), 0);

    rom_a[0] = 255; rom_b[0] = 255;
    rom_a[1] = 0;   rom_b[1] = 200;
    rom_a[2] = 255; rom_b[2] = 1;
    rom_a[3] = 128; rom_b[3] = 2;
    run();
    chk("t2_v0", 32'(cap[0]), 65025);
    chk("t2_v1", 32'(cap[1]), 0);
    chk("t2_v2", 32'(cap[2]), 255);
    chk("t2_v3", 32'(cap[3]), 256);
    chk("t2_err", 32'(err_count), 0);

    for (int k = 0; k < N; k++) begin
      rom_a[k] = 8'(k);
      rom_b[k] = 8'(k + 1);
    end
    fault_en = 1;
    run();
    chk("t3_err", 32'(err_count), 2);
    chk("t3_v5", 32'(cap[5]), 31);
    chk("t3_v9", 32'(cap[9]), 91);
    repeat (3) @(negedge clk);
    #2;
    chk("t3_err_hold", 32'(err_count), 2);
    fault_en = 0;
    run();
    chk("t3_err_clr", 32'(err_count), 0);

    n_we   = 0;
    n_done = 0;
    start  = 1;
    @(negedge clk);
    #2;
    start = 0;
    wait_rel(3);
    start = 1;
    @(negedge clk);
    #2;
    start = 0;
    wait_rel(10);
    start = 1;
    @(negedge clk);
    #2;
    start = 0;
    wait_done();
    repeat (5) @(negedge clk);
    #2;
    chk("t4_n_we", n_we, 16);
    chk("t4_n_done", n_done, 1);

    n_we   = 0;
    n_done = 0;
    start  = 1;
    @(negedge clk);
    #2;
    start = 0;
    wait_rel(8);
    reset_rtl = 1;
    @(negedge clk);
    #2;
    reset_rtl = 0;
    n_we   = 0;
    n_done = 0;
    repeat (25) @(negedge clk);
    #2;
    chk("t5_no_we", n_we, 0);
    chk("t5_no_done", n_done, 0);
    run();
    chk("t5_rerun_we", n_we, 16);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        rom_a[k] = 8'($urandom_range(0, 255));
        rom_b[k] = 8'($urandom_range(0, 255));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #2;
      run();
      chk("rnd_n_we", n_we, 16);
    end

    done_q.delete();
    t0    = cyc;
    start = 1;
    lows  = 0;
    low_at = 0;
    for (int r = 1; r < 60; r++) begin
      @(negedge clk);
      #1;
      if (r <= 43 && !busy) begin
        lows++;
        low_at = r;
      end
      #1;
    end
    start = 0;
    d0 = (done_q.size() > 0) ? done_q[0] - t0 : 0;
    d1 = (done_q.size() > 1) ? done_q[1] - t0 : 0;
    chk("t6_done0", d0, 21);
    chk("t6_done1", d1, 43);
    chk("t6_busy_lows", lows, 1);
    chk("t6_low_at", low_at, 22);
    wait_done();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
